// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: requester 0 (ALU result) and requester 1 (load/memory result).
// A round-robin arbiter grants one requester per cycle through a valid/ready
// handshake. The winning address/data is registered and presented to the
// register file one cycle after the transfer.
//
// Optional feature macro: WB_ARB_STATS_EN
//   When defined, adds per-requester saturating grant counters and a
//   registered "contended" flag. When undefined, those ports and all of
//   their logic are absent.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   hold         in   pipeline stall; suppresses all grants while high
//   req0_valid   in   requester 0 has a write pending
//   req0_addr    in   requester 0 destination register   [ADDR_W]
//   req0_data    in   requester 0 write data             [DATA_W]
//   req0_ready   out  requester 0 accepted this cycle
//   req1_valid   in   requester 1 has a write pending
//   req1_addr    in   requester 1 destination register   [ADDR_W]
//   req1_data    in   requester 1 write data             [DATA_W]
//   req1_ready   out  requester 1 accepted this cycle
//   mux_sel      out  select for external address mux (0=req0, 1=req1)
//   rf_we        out  register-file write enable (registered)
//   rf_waddr     out  register-file write address (registered) [ADDR_W]
//   rf_wdata     out  register-file write data (registered)    [DATA_W]
//   grant0_cnt   out  transfers granted to requester 0 (stats build) [CNT_W]
//   grant1_cnt   out  transfers granted to requester 1 (stats build) [CNT_W]
//   contended    out  both requesters valid last cycle, no hold (stats build)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              mux_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant0_cnt,
    output logic [CNT_W-1:0]  grant1_cnt,
    output logic              contended
`endif
);

    // Index of the most recent winner; the other requester wins a tie.
    logic              last_grant_q, last_grant_d;
    logic              mux_sel_q;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic              gnt0, gnt1, xfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // -------------------------------------------------------------------------
    // Grant and next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        if (!hold) begin
            if (req0_valid && req1_valid) begin
                // Tie: the requester that did not win last time goes now.
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end

        // A grant is only ever issued to a valid requester, so grant == transfer.
        xfer     = gnt0 | gnt1;
        sel_addr = gnt1 ? req1_addr : req0_addr;
        sel_data = gnt1 ? req1_data : req0_data;

        if (xfer) begin
            last_grant_d = gnt1;
            // Writes to $zero are accepted but never reach the register file;
            // the previous address/data stay on the port.
            if (sel_addr != '0) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = sel_addr;
                rf_wdata_d = sel_data;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    // Follows the live grant so the external mux switches in the same cycle;
    // otherwise it parks on the last winner and never toggles spuriously.
    assign mux_sel    = xfer ? gnt1 : mux_sel_q;

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            last_grant_q <= 1'b1;
            mux_sel_q    <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            mux_sel_q    <= mux_sel;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

`ifdef WB_ARB_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics: saturating per-requester transfer counters and a registered
    // contention flag.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] grant0_cnt_q, grant1_cnt_q;
    logic             contended_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_cnt_q <= '0;
            grant1_cnt_q <= '0;
            contended_q  <= 1'b0;
        end else begin
            if (gnt0 && (grant0_cnt_q != '1)) grant0_cnt_q <= grant0_cnt_q + 1'b1;
            if (gnt1 && (grant1_cnt_q != '1)) grant1_cnt_q <= grant1_cnt_q + 1'b1;
            contended_q <= req0_valid & req1_valid & ~hold;
        end
    end

    assign grant0_cnt = grant0_cnt_q;
    assign grant1_cnt = grant1_cnt_q;
    assign contended  = contended_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Self-checking bench for wb_port_arbiter. Directed sequences followed by
// randomized traffic, all compared against a transaction-level reference
// model: "who wins this cycle" is decided from the arbitration rules, and
// the expected register-file write is the winner's request one cycle later.
// Define WB_ARB_STATS_EN to also exercise the statistics outputs.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              hold;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              mux_sel;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
    logic [CNT_W-1:0]  grant0_cnt, grant1_cnt;
    logic              contended;
`endif

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .hold       (hold),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .mux_sel    (mux_sel),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
`ifdef WB_ARB_STATS_EN
        ,
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt),
        .contended  (contended)
`endif
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model state (transaction level)
    // -------------------------------------------------------------------------
    bit              m_init = 0;     // model known only after the first reset
    int              m_last = 1;     // most recent winner
    int              m_mux  = 0;     // last shown mux select
    bit              m_we   = 0;     // expected rf_we this cycle
    bit              m_known = 1;    // rf_waddr/rf_wdata are defined by the rules
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    int              m_cnt0 = 0, m_cnt1 = 0;
    bit              m_cont = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    // Entered and left just after a rising edge. Returns the winner (-1 = none).
    task automatic run_cycle(input bit r, input bit h,
                             input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                             input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                             output int g);
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        reset = r; hold = h;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;

        g = -1;
        if (!h) begin
            if (v0 && v1)  g = 1 - m_last;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end

        @(negedge clk);
        if (m_init) begin
            check("rf_we", rf_we, m_we);
            if (m_known) begin
                check("rf_waddr", rf_waddr, m_waddr);
                check("rf_wdata", rf_wdata, m_wdata);
            end
`ifdef WB_ARB_STATS_EN
            check("grant0_cnt", grant0_cnt, m_cnt0);
            check("grant1_cnt", grant1_cnt, m_cnt1);
            check("contended", contended, m_cont);
`endif
        end
        if (!r && m_init) begin
            check("req0_ready", req0_ready, (g == 0));
            check("req1_ready", req1_ready, (g == 1));
            check("mux_sel", mux_sel, (g >= 0) ? g : m_mux);
            // never more than one ready
            check("one_hot_ready", req0_ready & req1_ready, 1'b0);
        end

        // Advance the model to what the next cycle must show.
        if (r) begin
            m_init = 1; m_last = 1; m_mux = 0; m_we = 0; m_known = 1;
            m_waddr = '0; m_wdata = '0; m_cnt0 = 0; m_cnt1 = 0; m_cont = 0;
            g = -1;
        end else begin
            m_cont = v0 && v1 && !h;
            if (g >= 0) begin
                wa = (g == 1) ? a1 : a0;
                wd = (g == 1) ? d1 : d0;
                m_last = g;
                m_mux  = g;
                if (g == 0 && m_cnt0 < CNT_MAX) m_cnt0++;
                if (g == 1 && m_cnt1 < CNT_MAX) m_cnt1++;
                if (wa != '0) begin
                    m_we = 1; m_waddr = wa; m_wdata = wd; m_known = 1;
                end else begin
                    // address/data left on the port after a $zero transfer are not defined
                    m_we = 0; m_known = 0;
                end
            end else begin
                m_we = 0;
            end
        end

        @(posedge clk);
        #1;
    endtask

    int g;
    int w0_cnt, w1_cnt;
    bit p0, p1;
    logic [ADDR_W-1:0] ra0, ra1;
    logic [DATA_W-1:0] rd0, rd1;

    initial begin
        reset = 1; hold = 0;
        req0_valid = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_addr = '0; req1_data = '0;
        @(posedge clk); #1;

        // Reset
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, g);
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, g);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);   // reset values checked here

        // req0 alone
        run_cycle(0, 0, 1, 5'b01010, 32'h0000_00AA, 0, 0, 0, g);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);   // write visible here

        // Continuous contention after reset: 0,1,0,1
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, g);
        for (int i = 0; i < 4; i++) begin
            run_cycle(0, 0, 1, 5'b10101, 32'h1111_0000 + i, 1, 5'b00011, 32'h2222_0000 + i, g);
            check("rr_order", g, i % 2);
        end
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);

        // Hold with both valid, then release: requester 0 wins (last was 1)
        run_cycle(0, 1, 1, 5'd7, 32'h7777_7777, 1, 5'd9, 32'h9999_9999, g);
        run_cycle(0, 1, 1, 5'd7, 32'h7777_7777, 1, 5'd9, 32'h9999_9999, g);
        run_cycle(0, 0, 1, 5'd7, 32'h7777_7777, 1, 5'd9, 32'h9999_9999, g);
        check("hold_release_winner", g, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);

        // $zero write from requester 1, then contention goes to requester 0
        run_cycle(0, 0, 0, 0, 0, 1, 5'd0, 32'hDEAD_BEEF, g);
        run_cycle(0, 0, 1, 5'd4, 32'h4444_4444, 1, 5'd6, 32'h6666_6666, g);
        check("after_zero_winner", g, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);

        // Transfer in the same cycle as reset: dropped
        run_cycle(1, 0, 1, 5'd12, 32'hCAFE_0001, 0, 0, 0, g);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
        run_cycle(0, 0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, g);
        check("post_reset_winner", g, 0);

        // Randomized traffic obeying the hold-until-ready rule
        p0 = 0; p1 = 0;
        ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        w0_cnt = 0; w1_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            bit rr, hh;
            if (!p0 || $urandom_range(0, 9) == 0) begin
                p0  = ($urandom_range(0, 3) != 0);
                ra0 = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
                rd0 = $urandom;
            end
            if (!p1 || $urandom_range(0, 9) == 0) begin
                p1  = ($urandom_range(0, 3) != 0);
                ra1 = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom);
                rd1 = $urandom;
            end
            rr = ($urandom_range(0, 63) == 0);
            hh = ($urandom_range(0, 7) == 0);
            run_cycle(rr, hh, p0, ra0, rd0, p1, ra1, rd1, g);
            // starvation: a contended, unheld requester never waits two cycles
            if (p0 && p1 && !hh && !rr) begin
                if (g == 0) begin w0_cnt = 0; w1_cnt++; end
                else        begin w1_cnt = 0; w0_cnt++; end
                if (w0_cnt > 1 || w1_cnt > 1) check("starvation", 1, 0);
            end else begin
                w0_cnt = 0; w1_cnt = 0;
            end
            if (g == 0) p0 = 0;
            if (g == 1) p1 = 0;
        end
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);

`ifdef WB_ARB_STATS_EN
        // 1 contended (goes to 0), 2 more req0, 2 req1 -> 3 / 2
        run_cycle(1, 0, 0, 0, 0, 0, 0, 0, g);
        run_cycle(0, 0, 1, 5'd3, 32'h3, 1, 5'd8, 32'h8, g);
        run_cycle(0, 0, 1, 5'd3, 32'h3, 0, 0, 0, g);
        run_cycle(0, 0, 1, 5'd0, 32'h0, 0, 0, 0, g);
        run_cycle(0, 0, 0, 0, 0, 1, 5'd8, 32'h8, g);
        run_cycle(0, 0, 0, 0, 0, 1, 5'd9, 32'h9, g);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
        check("grant0_cnt_final", grant0_cnt, 3);
        check("grant1_cnt_final", grant1_cnt, 2);

        // Saturation of the requester 0 counter
        for (int i = 0; i < CNT_MAX + 4; i++)
            run_cycle(0, 0, 1, 5'd17, i, 0, 0, 0, g);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0, g);
        check("grant0_cnt_sat", grant0_cnt, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
